// File: rtl/lcm_3wire_controller.sv
// 3-wire LCM panel serial engine: shifts one {addr,rw,ta,data} word per strobe,
// captures read data, and generates the sequencer tick clock oCLK.
//   IDLE  | idle, oRDY=1, waiting for an armed strobe
//   SETUP | I2S_EN low, clock high, bit 15 presented
//   SHIFT | 16 bits, low half then high half per bit
//   HOLD  | clock high, I2S_EN still low
//   GAP   | I2S_EN high, quiet time before oRDY returns
module lcm_3wire_controller #(
    parameter int CLK_DIV  = 16,
    parameter int SCLK_DIV = 64,
    parameter int GAP_CYC  = 32
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [15:0] iDATA,
    input  logic        iSTR,
    output logic        oACK,
    output logic        oRDY,
    output logic [7:0]  oRDATA,
    output logic        oCLK,
    output logic        I2S_EN,
    output logic        I2S_CLK,
    inout  wire         I2S_DATA
);

    localparam int CD_W   = $clog2(CLK_DIV);
    localparam int HC_MAX = (SCLK_DIV > GAP_CYC) ? SCLK_DIV : GAP_CYC;
    localparam int HC_W   = $clog2(HC_MAX);

    localparam logic [CD_W-1:0] CD_LAST  = CD_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0] SC_LAST  = HC_W'(SCLK_DIV - 1);
    localparam logic [HC_W-1:0] GAP_LAST = HC_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} stateT;

    stateT            state;
    logic [CD_W-1:0]  clkCnt;
    logic [HC_W-1:0]  hc;
    logic [3:0]       bc;
    logic             hiHalf;
    logic [14:0]      sh;
    logic             rwq;
    logic [7:0]       rd;
    logic             done;
    logic             strq;
    logic             armed;
    logic             dataOut;
    logic             dataOe;

    assign I2S_DATA = dataOe ? dataOut : 1'bz;

    // Tick clock is independent of the frame engine so the sequencer never sees a phase jump.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            clkCnt <= '0;
            oCLK   <= 1'b0;
        end else if (clkCnt == CD_LAST) begin
            clkCnt <= '0;
            oCLK   <= ~oCLK;
        end else begin
            clkCnt <= clkCnt + CD_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            strq    <= 1'b0;
            armed   <= 1'b0;
            hc      <= '0;
            bc      <= '0;
            hiHalf  <= 1'b0;
            sh      <= '0;
            rwq     <= 1'b0;
            rd      <= '0;
            done    <= 1'b0;
            oRDY    <= 1'b1;
            oACK    <= 1'b0;
            oRDATA  <= '0;
            I2S_EN  <= 1'b1;
            I2S_CLK <= 1'b1;
            dataOut <= 1'b0;
            dataOe  <= 1'b1;
        end else begin
            strq <= iSTR;
            if (!strq)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (strq && armed) begin
                        armed   <= 1'b0;
                        sh      <= iDATA[14:0];
                        rwq     <= iDATA[9];
                        dataOut <= iDATA[15];
                        dataOe  <= 1'b1;
                        oRDY    <= 1'b0;
                        I2S_EN  <= 1'b0;
                        I2S_CLK <= 1'b1;
                        hc      <= '0;
                        done    <= 1'b0;
                        state   <= SETUP;
                    end
                end

                GAP: begin
                    if (hc == GAP_LAST) begin
                        hc    <= '0;
                        oRDY  <= 1'b1;
                        oACK  <= done;
                        if (done && rwq)
                            oRDATA <= rd;
                        state <= IDLE;
                    end else begin
                        hc <= hc + HC_W'(1);
                    end
                end

                default: begin
                    if (!strq) begin
                        // Sequencer withdrew the request: release the bus at once.
                        state   <= GAP;
                        hc      <= '0;
                        I2S_EN  <= 1'b1;
                        I2S_CLK <= 1'b1;
                        dataOut <= 1'b0;
                        dataOe  <= 1'b1;
                        oACK    <= 1'b0;
                        done    <= 1'b0;
                    end else if (hc != SC_LAST) begin
                        hc <= hc + HC_W'(1);
                    end else begin
                        hc <= '0;
                        case (state)
                            SETUP: begin
                                state   <= SHIFT;
                                bc      <= '0;
                                hiHalf  <= 1'b0;
                                I2S_CLK <= 1'b0;
                            end
                            SHIFT: begin
                                if (!hiHalf) begin
                                    hiHalf  <= 1'b1;
                                    I2S_CLK <= 1'b1;
                                end else begin
                                    if (rwq && bc[3])
                                        rd <= {rd[6:0], I2S_DATA};
                                    if (bc == 4'd15) begin
                                        state   <= HOLD;
                                        dataOut <= 1'b0;
                                        dataOe  <= 1'b1;
                                    end else begin
                                        bc      <= bc + 4'd1;
                                        hiHalf  <= 1'b0;
                                        I2S_CLK <= 1'b0;
                                        sh      <= {sh[13:0], 1'b0};
                                        dataOut <= sh[14];
                                        dataOe  <= !(rwq && (bc >= 4'd7));
                                    end
                                end
                            end
                            HOLD: begin
                                state  <= GAP;
                                I2S_EN <= 1'b1;
                                done   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_3wire_controller.sv
// Directed bench for lcm_3wire_controller with a small panel model on the 3-wire bus.
module tb_lcm_3wire_controller;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [15:0] iDATA;
    logic        iSTR;
    logic        oACK, oRDY, oCLK, I2S_EN, I2S_CLK;
    logic [7:0]  oRDATA;
    wire         I2S_DATA;

    logic        panelOe = 1'b0;
    logic        panelBit = 1'b0;
    logic        panelEn = 1'b0;
    logic [7:0]  panelByte = 8'h00;

    int          checks = 0;
    int          errors = 0;
    logic        prevSclk = 1'b1;
    logic        prevEn = 1'b1;
    int          riseCnt = 0;
    int          fallCnt = 0;
    int          frameCnt = 0;
    logic [15:0] capWord = 16'h0000;

    assign I2S_DATA = panelOe ? panelBit : 1'bz;

    lcm_3wire_controller #(.CLK_DIV(2), .SCLK_DIV(4), .GAP_CYC(8)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iSTR(iSTR),
        .oACK(oACK), .oRDY(oRDY), .oRDATA(oRDATA), .oCLK(oCLK),
        .I2S_EN(I2S_EN), .I2S_CLK(I2S_CLK), .I2S_DATA(I2S_DATA)
    );

    always #5 iCLK = ~iCLK;

    // Bus monitor and panel: captures bits at I2S_CLK rises, drives read data after falls.
    always @(negedge iCLK) begin
        if (!I2S_EN && prevEn) begin
            riseCnt = 0; fallCnt = 0; capWord = 16'h0000; frameCnt++;
        end
        if (I2S_EN) begin
            panelOe = 1'b0;
        end else if (I2S_CLK && !prevSclk) begin
            capWord = {capWord[14:0], I2S_DATA};
            riseCnt++;
        end else if (!I2S_CLK && prevSclk) begin
            if (panelEn && fallCnt >= 8) begin
                panelOe  = 1'b1;
                panelBit = panelByte[15 - fallCnt];
            end
            fallCnt++;
        end
        prevSclk = I2S_CLK;
        prevEn   = I2S_EN;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic runFrame(input logic [15:0] word, output int rdyLat, output int enLow,
                            output int gapLen, output bit timedOut);
        timedOut = 1'b0; rdyLat = 0; enLow = 0; gapLen = 0;
        @(negedge iCLK);
        iDATA = word;
        iSTR  = 1'b1;
        do begin
            @(negedge iCLK);
            rdyLat++;
        end while (oRDY && rdyLat < 20);
        if (oRDY) begin
            timedOut = 1'b1;
        end else begin
            while (!I2S_EN && enLow < 1000) begin enLow++; @(negedge iCLK); end
            while (!oRDY && gapLen < 100) begin gapLen++; @(negedge iCLK); end
            if (enLow >= 1000 || gapLen >= 100) timedOut = 1'b1;
        end
    endtask

    task automatic test_reset;
        iRST_N = 1'b0; iSTR = 1'b0; iDATA = 16'h0000;
        repeat (3) @(negedge iCLK);
        checks++; if (oRDY !== 1'b1)    begin errors++; $display("FAIL reset_rdy: got %b want 1", oRDY); end
        checks++; if (oACK !== 1'b0)    begin errors++; $display("FAIL reset_ack: got %b want 0", oACK); end
        checks++; if (oRDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", oRDATA); end
        checks++; if (oCLK !== 1'b0)    begin errors++; $display("FAIL reset_oclk: got %b want 0", oCLK); end
        checks++; if (I2S_EN !== 1'b1)  begin errors++; $display("FAIL reset_en: got %b want 1", I2S_EN); end
        checks++; if (I2S_CLK !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", I2S_CLK); end
        checks++; if (I2S_DATA !== 1'b0) begin errors++; $display("FAIL reset_data: got %b want 0", I2S_DATA); end
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);
        checks++; if (I2S_EN !== 1'b1 || oRDY !== 1'b1)
            begin errors++; $display("FAIL reset_idle: got en=%b rdy=%b want 1 1", I2S_EN, oRDY); end
    endtask

    task automatic test_write;
        int lat, enLow, gap; bit to;
        runFrame(16'h0802, lat, enLow, gap, to);
        checks++; if (to)               begin errors++; $display("FAIL write_timeout: frame did not complete"); end
        checks++; if (lat != 2)         begin errors++; $display("FAIL write_rdy_latency: got %0d want 2", lat); end
        checks++; if (capWord !== 16'h0802) begin errors++; $display("FAIL write_word: got %h want 0802", capWord); end
        checks++; if (riseCnt != 16)    begin errors++; $display("FAIL write_rises: got %0d want 16", riseCnt); end
        checks++; if (enLow != 136)     begin errors++; $display("FAIL write_en_low: got %0d want 136", enLow); end
        checks++; if (gap != 8)         begin errors++; $display("FAIL write_gap: got %0d want 8", gap); end
        checks++; if (oACK !== 1'b1)    begin errors++; $display("FAIL write_ack: got %b want 1", oACK); end
        checks++; if (oRDATA !== 8'h00) begin errors++; $display("FAIL write_rdata: got %h want 00", oRDATA); end
        iSTR = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_read(input logic [15:0] word, input logic [7:0] pbyte, input logic [15:0] expWord);
        int lat, enLow, gap; bit to;
        panelEn = 1'b1; panelByte = pbyte;
        runFrame(word, lat, enLow, gap, to);
        checks++; if (to)                  begin errors++; $display("FAIL read_timeout: frame did not complete"); end
        checks++; if (capWord !== expWord) begin errors++; $display("FAIL read_word: got %h want %h", capWord, expWord); end
        checks++; if (oRDATA !== pbyte)    begin errors++; $display("FAIL read_rdata: got %h want %h", oRDATA, pbyte); end
        checks++; if (oACK !== 1'b1)       begin errors++; $display("FAIL read_ack: got %b want 1", oACK); end
        iSTR = 1'b0; panelEn = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_abort;
        int n, gap;
        n = 0;
        @(negedge iCLK);
        iDATA = 16'hA4C3; iSTR = 1'b1;
        while (!(!I2S_EN && riseCnt == 5) && n < 500) begin @(negedge iCLK); n++; end
        checks++; if (n >= 500) begin errors++; $display("FAIL abort_timeout: 5th rise not seen"); end
        iSTR = 1'b0;
        @(negedge iCLK);
        checks++; if (I2S_EN !== 1'b0)  begin errors++; $display("FAIL abort_en_early: got %b want 0", I2S_EN); end
        @(negedge iCLK);
        checks++; if (I2S_EN !== 1'b1)  begin errors++; $display("FAIL abort_en: got %b want 1", I2S_EN); end
        checks++; if (I2S_CLK !== 1'b1) begin errors++; $display("FAIL abort_sclk: got %b want 1", I2S_CLK); end
        checks++; if (oACK !== 1'b0)    begin errors++; $display("FAIL abort_ack: got %b want 0", oACK); end
        gap = 0;
        while (!oRDY && gap < 100) begin gap++; @(negedge iCLK); end
        checks++; if (gap != 8)         begin errors++; $display("FAIL abort_gap: got %0d want 8", gap); end
        checks++; if (oRDATA !== 8'h3C) begin errors++; $display("FAIL abort_rdata: got %h want 3c", oRDATA); end
        checks++; if (riseCnt != 5 || capWord !== 16'h0014)
            begin errors++; $display("FAIL abort_bits: got %0d rises word %h want 5 rises word 0014", riseCnt, capWord); end
        checks++; if (oACK !== 1'b0)    begin errors++; $display("FAIL abort_ack_final: got %b want 0", oACK); end
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_back_to_back;
        int lat, enLow, gap, f0; bit to;
        runFrame(16'h1155, lat, enLow, gap, to);
        checks++; if (to || capWord !== 16'h1155)
            begin errors++; $display("FAIL b2b_first: got to=%b word %h want 0 1155", to, capWord); end
        checks++; if (oACK !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b want 1", oACK); end
        f0 = frameCnt;
        repeat (40) @(negedge iCLK);
        checks++; if (frameCnt != f0 || I2S_EN !== 1'b1 || oRDY !== 1'b1)
            begin errors++; $display("FAIL b2b_no_retrigger: got frames %0d en=%b rdy=%b want %0d 1 1", frameCnt, I2S_EN, oRDY, f0); end
        @(negedge iCLK);
        iSTR = 1'b0;
        runFrame(16'h1166, lat, enLow, gap, to);
        checks++; if (to)                    begin errors++; $display("FAIL b2b_timeout: second frame did not complete"); end
        checks++; if (lat != 2)              begin errors++; $display("FAIL b2b_latency: got %0d want 2", lat); end
        checks++; if (frameCnt != f0 + 1)    begin errors++; $display("FAIL b2b_frames: got %0d want %0d", frameCnt, f0 + 1); end
        checks++; if (capWord !== 16'h1166)  begin errors++; $display("FAIL b2b_word: got %h want 1166", capWord); end
        checks++; if (enLow != 136)          begin errors++; $display("FAIL b2b_en_low: got %0d want 136", enLow); end
        iSTR = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_reset_mid;
        int n, lat, enLow, gap; bit to;
        n = 0;
        @(negedge iCLK);
        iDATA = 16'hFCFF; iSTR = 1'b1;
        while (!(!I2S_EN && riseCnt == 3) && n < 500) begin @(negedge iCLK); n++; end
        checks++; if (n >= 500) begin errors++; $display("FAIL rstmid_timeout: 3rd rise not seen"); end
        #2 iRST_N = 1'b0;
        #1;
        checks++; if (I2S_EN !== 1'b1)   begin errors++; $display("FAIL rstmid_en: got %b want 1", I2S_EN); end
        checks++; if (I2S_CLK !== 1'b1)  begin errors++; $display("FAIL rstmid_sclk: got %b want 1", I2S_CLK); end
        checks++; if (I2S_DATA !== 1'b0) begin errors++; $display("FAIL rstmid_data: got %b want 0", I2S_DATA); end
        checks++; if (oRDY !== 1'b1)     begin errors++; $display("FAIL rstmid_rdy: got %b want 1", oRDY); end
        checks++; if (oACK !== 1'b0)     begin errors++; $display("FAIL rstmid_ack: got %b want 0", oACK); end
        checks++; if (oRDATA !== 8'h00)  begin errors++; $display("FAIL rstmid_rdata: got %h want 00", oRDATA); end
        checks++; if (oCLK !== 1'b0)     begin errors++; $display("FAIL rstmid_oclk: got %b want 0", oCLK); end
        iSTR = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        runFrame(16'h0802, lat, enLow, gap, to);
        checks++; if (to || capWord !== 16'h0802)
            begin errors++; $display("FAIL rstmid_clean_word: got to=%b word %h want 0 0802", to, capWord); end
        checks++; if (enLow != 136 || oACK !== 1'b1)
            begin errors++; $display("FAIL rstmid_clean_frame: got en_low %0d ack %b want 136 1", enLow, oACK); end
        iSTR = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_oclk;
        int run, toggles, bad;
        logic prev;
        run = 0; toggles = 0; bad = 0;
        @(negedge iCLK);
        iDATA = 16'h0802; iSTR = 1'b1;
        prev = oCLK;
        for (int i = 0; i < 1000; i++) begin
            @(negedge iCLK);
            run++;
            if (oCLK !== prev) begin
                if (toggles > 0 && run != 2) bad++;
                toggles++;
                run = 0;
                prev = oCLK;
            end
        end
        checks++; if (bad != 0)      begin errors++; $display("FAIL oclk_period: got %0d bad half-periods want 0", bad); end
        checks++; if (toggles != 500) begin errors++; $display("FAIL oclk_toggles: got %0d want 500", toggles); end
        iSTR = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read(16'h2600, 8'hA5, 16'h26A5);
        test_read(16'h265A, 8'h3C, 16'h263C);
        test_abort;
        test_back_to_back;
        test_reset_mid;
        test_oclk;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
